// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use and branch
// bubbles, and data-memory wait stalls, with a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int REG_W     = 4,
  parameter int NSRC      = 2,
  parameter int LU_CYC    = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC*REG_W-1:0]  id_src,
  input  logic [NSRC*REG_W-1:0]  ex_src,
  input  logic [REG_W-1:0]       ex_dst,
  input  logic                   ex_regwrite,
  input  logic                   ex_memread,
  input  logic [REG_W-1:0]       mem_dst,
  input  logic                   mem_regwrite,
  input  logic                   mem_memwrite,
  input  logic [REG_W-1:0]       mem_st_src,
  input  logic [REG_W-1:0]       wb_dst,
  input  logic                   wb_regwrite,
  input  logic                   br_taken,
  input  logic                   dmem_busy,
  output logic [NSRC*2-1:0]      fwd_sel,
  output logic                   mem_mem_fw,
  output logic [3:0]             hold,
  output logic [3:0]             no_op,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LU    = 2'd1,
    ST_FLUSH = 2'd2,
    ST_MEMW  = 2'd3
  } state_t;

  state_t         state_r, state_nx_s, ret_r, ret_nx_s, rule_state_s;
  logic [3:0]     cnt_r, cnt_nx_s;
  logic [3:0]     hold_s, no_op_s;
  logic           load_use_s;
  logic [CNT_W-1:0] stall_cnt_r;

  function automatic logic [1:0] fwd_code(
    input logic [REG_W-1:0] src,
    input logic             m_we,
    input logic [REG_W-1:0] m_dst,
    input logic             w_we,
    input logic [REG_W-1:0] w_dst
  );
    if (m_we && (m_dst != '0) && (m_dst == src)) begin
      return 2'b01;
    end else if (w_we && (w_dst != '0) && (w_dst == src)) begin
      return 2'b10;
    end else begin
      return 2'b00;
    end
  endfunction

  // Per-slot forwarding selects and store-data forward
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      fwd_sel[2*i +: 2] = fwd_code(ex_src[i*REG_W +: REG_W], mem_regwrite, mem_dst,
                                   wb_regwrite, wb_dst);
    end
    mem_mem_fw = mem_memwrite & wb_regwrite & (wb_dst != '0) & (wb_dst == mem_st_src);
  end

  // Load-use detection against any IF/ID source slot
  always_comb begin
    load_use_s = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_src[i*REG_W +: REG_W] == ex_dst) begin
        load_use_s = 1'b1;
      end else begin
        load_use_s = load_use_s;
      end
    end
    load_use_s = load_use_s & ex_memread & (ex_dst != '0);
  end

  // Once memory is ready, MEMW behaves exactly like the state it interrupted
  always_comb begin
    if ((state_r == ST_MEMW) && !dmem_busy) begin
      rule_state_s = ret_r;
    end else begin
      rule_state_s = state_r;
    end
  end

  // Next-state, counter and stall/bubble controls
  always_comb begin
    hold_s     = 4'b0000;
    no_op_s    = 4'b0000;
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    ret_nx_s   = ret_r;
    case (rule_state_s)
      ST_RUN: begin
        state_nx_s = ST_RUN;
        if (dmem_busy) begin
          hold_s     = 4'b0111;
          no_op_s    = 4'b1000;
          state_nx_s = ST_MEMW;
          ret_nx_s   = ST_RUN;
        end else if (load_use_s) begin
          hold_s  = 4'b0001;
          no_op_s = 4'b0010;
          if (LU_CYC > 1) begin
            state_nx_s = ST_LU;
            cnt_nx_s   = 4'(LU_CYC - 1);
          end else begin
            state_nx_s = ST_RUN;
          end
        end else if (br_taken) begin
          no_op_s = 4'b0001;
          if (FLUSH_CYC > 1) begin
            state_nx_s = ST_FLUSH;
            cnt_nx_s   = 4'(FLUSH_CYC - 1);
          end else begin
            state_nx_s = ST_RUN;
          end
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_LU, ST_FLUSH: begin
        if (dmem_busy) begin
          hold_s     = 4'b0111;
          no_op_s    = 4'b1000;
          state_nx_s = ST_MEMW;
          ret_nx_s   = rule_state_s;
        end else begin
          if (rule_state_s == ST_LU) begin
            hold_s  = 4'b0001;
            no_op_s = 4'b0010;
          end else begin
            no_op_s = 4'b0001;
          end
          cnt_nx_s = (cnt_r != 4'd0) ? (cnt_r - 4'd1) : 4'd0;
          if (cnt_r <= 4'd1) begin
            state_nx_s = ST_RUN;
          end else begin
            state_nx_s = rule_state_s;
          end
        end
      end
      ST_MEMW: begin
        hold_s     = 4'b0111;
        no_op_s    = 4'b1000;
        state_nx_s = ST_MEMW;
      end
      default: begin
        state_nx_s = ST_RUN;
        cnt_nx_s   = 4'd0;
        ret_nx_s   = ST_RUN;
      end
    endcase
  end

  // Reset masks all stall and bubble requests
  always_comb begin
    if (rst) begin
      hold  = 4'b0000;
      no_op = 4'b0000;
    end else begin
      hold  = hold_s;
      no_op = no_op_s;
    end
  end

  // FSM, bubble counter, return state and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      cnt_r       <= 4'd0;
      ret_r       <= ST_RUN;
      stall_cnt_r <= '0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      ret_r   <= ret_nx_s;
      if ((hold_s != 4'b0000) && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign state     = state_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random stimulus, compared against a bubble-bookkeeping reference model.
module tb_pipe_hazard_ctrl;
  localparam int REG_W = 4, NSRC = 2, LU_CYC = 2, FLUSH_CYC = 3, CNT_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [NSRC*REG_W-1:0] id_src, ex_src;
  logic [REG_W-1:0] ex_dst, mem_dst, mem_st_src, wb_dst;
  logic ex_regwrite, ex_memread, mem_regwrite, mem_memwrite, wb_regwrite, br_taken, dmem_busy;
  logic [NSRC*2-1:0] fwd_sel;
  logic mem_mem_fw;
  logic [3:0] hold, no_op;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0] state;

  pipe_hazard_ctrl #(.REG_W(REG_W), .NSRC(NSRC), .LU_CYC(LU_CYC), .FLUSH_CYC(FLUSH_CYC),
                     .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_src(id_src), .ex_src(ex_src), .ex_dst(ex_dst),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_dst(mem_dst),
    .mem_regwrite(mem_regwrite), .mem_memwrite(mem_memwrite), .mem_st_src(mem_st_src),
    .wb_dst(wb_dst), .wb_regwrite(wb_regwrite), .br_taken(br_taken), .dmem_busy(dmem_busy),
    .fwd_sel(fwd_sel), .mem_mem_fw(mem_mem_fw), .hold(hold), .no_op(no_op),
    .stall_cnt(stall_cnt), .state(state)
  );

  int total = 0;
  int bad   = 0;

  // Model: remaining load-use bubbles, remaining flush cycles, waiting-on-memory flag
  int m_lu, m_fl, m_stall;
  bit m_memw;
  int n_lu, n_fl, n_stall;
  bit n_memw;
  logic [3:0] e_hold, e_noop;
  logic [NSRC*2-1:0] e_fwd;
  logic e_mmf;
  int e_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    logic lu;
    e_mmf = mem_memwrite && wb_regwrite && (wb_dst != 0) && (wb_dst == mem_st_src);
    for (int i = 0; i < NSRC; i++) begin
      logic [REG_W-1:0] s;
      s = ex_src[i*REG_W +: REG_W];
      if (mem_regwrite && mem_dst != 0 && mem_dst == s) e_fwd[2*i +: 2] = 2'b01;
      else if (wb_regwrite && wb_dst != 0 && wb_dst == s) e_fwd[2*i +: 2] = 2'b10;
      else e_fwd[2*i +: 2] = 2'b00;
    end
    lu = 1'b0;
    for (int i = 0; i < NSRC; i++) if (id_src[i*REG_W +: REG_W] == ex_dst) lu = 1'b1;
    lu = lu && ex_memread && (ex_dst != 0);
    e_state = m_memw ? 3 : (m_lu > 0) ? 1 : (m_fl > 0) ? 2 : 0;
    e_hold = 4'b0000; e_noop = 4'b0000;
    n_lu = m_lu; n_fl = m_fl; n_memw = m_memw; n_stall = m_stall;
    if (rst) begin
      n_lu = 0; n_fl = 0; n_memw = 0; n_stall = 0;
    end else begin
      if (dmem_busy) begin
        e_hold = 4'b0111; e_noop = 4'b1000; n_memw = 1;
      end else begin
        n_memw = 0;
        if (m_lu > 0) begin
          e_hold = 4'b0001; e_noop = 4'b0010; n_lu = m_lu - 1;
        end else if (m_fl > 0) begin
          e_noop = 4'b0001; n_fl = m_fl - 1;
        end else if (lu) begin
          e_hold = 4'b0001; e_noop = 4'b0010; n_lu = LU_CYC - 1;
        end else if (br_taken) begin
          e_noop = 4'b0001; n_fl = FLUSH_CYC - 1;
        end
      end
      if (e_hold != 0) n_stall = (m_stall + 1 > 7) ? 7 : m_stall + 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    chk("hold", 32'(hold), 32'(e_hold));
    chk("no_op", 32'(no_op), 32'(e_noop));
    chk("fwd_sel", 32'(fwd_sel), 32'(e_fwd));
    chk("mem_mem_fw", 32'(mem_mem_fw), 32'(e_mmf));
    chk("state", 32'(state), 32'(e_state));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    @(posedge clk);
    m_lu = n_lu; m_fl = n_fl; m_memw = n_memw; m_stall = n_stall;
    #1;
  endtask

  task automatic idle();
    id_src = '0; ex_src = '0; ex_dst = '0; mem_dst = '0; mem_st_src = '0; wb_dst = '0;
    ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0; mem_memwrite = 0;
    wb_regwrite = 0; br_taken = 0; dmem_busy = 0;
  endtask

  task automatic set_load_use();
    ex_memread = 1; ex_regwrite = 1; ex_dst = 4'd5; id_src = {4'd5, 4'd0};
  endtask

  initial begin
    m_lu = 0; m_fl = 0; m_memw = 0; m_stall = 0;
    idle();
    rst = 1;
    dmem_busy = 1; br_taken = 1;
    cycle(); cycle();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_stall", 32'(stall_cnt), 32'd0);
    rst = 0; idle();

    // Forwarding priority
    ex_src = {4'd0, 4'd3}; mem_dst = 4'd3; wb_dst = 4'd3; mem_regwrite = 1; wb_regwrite = 1;
    #1 chk("fwd_mem_wins", 32'(fwd_sel[1:0]), 32'd1);
    mem_dst = 4'd0;
    #1 chk("fwd_wb", 32'(fwd_sel[1:0]), 32'd2);
    mem_memwrite = 1; mem_st_src = 4'd3;
    cycle();
    idle();

    // Load-use: two bubbles
    set_load_use();
    cycle();
    chk("lu_enter", 32'(state), 32'd1);
    idle();
    cycle();
    chk("lu_exit", 32'(state), 32'd0);
    chk("lu_stall", 32'(stall_cnt), 32'd2);

    // Flush: three squash cycles
    br_taken = 1;
    cycle();
    chk("fl_enter", 32'(state), 32'd2);
    br_taken = 0;
    cycle(); cycle();
    chk("fl_exit", 32'(state), 32'd0);

    // Memory wait nested inside load-use
    set_load_use();
    cycle();
    idle();
    dmem_busy = 1;
    repeat (4) cycle();
    chk("nest_memw", 32'(state), 32'd3);
    dmem_busy = 0;
    #1 chk("nest_resume_hold", 32'(hold), 32'd1);
    cycle();
    chk("nest_back", 32'(state), 32'd0);

    // Event priority
    rst = 1; cycle(); rst = 0;
    set_load_use(); br_taken = 1;
    cycle();
    chk("prio_lu", 32'(state), 32'd1);
    idle(); cycle();
    set_load_use(); br_taken = 1; dmem_busy = 1;
    cycle();
    chk("prio_memw", 32'(state), 32'd3);
    idle(); cycle();

    // Saturation, then reset mid-MEMW
    rst = 1; cycle(); rst = 0;
    dmem_busy = 1;
    repeat (10) cycle();
    chk("sat_cnt", 32'(stall_cnt), 32'd7);
    rst = 1;
    cycle();
    rst = 0; idle();
    #1;
    chk("rst_memw_state", 32'(state), 32'd0);
    chk("rst_memw_hold", 32'(hold), 32'd0);
    chk("rst_memw_stall", 32'(stall_cnt), 32'd0);

    // Random stimulus against the model
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      id_src = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      ex_src = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      ex_dst = 4'($urandom_range(0, 3));
      mem_dst = 4'($urandom_range(0, 3));
      mem_st_src = 4'($urandom_range(0, 3));
      wb_dst = 4'($urandom_range(0, 3));
      ex_regwrite = 1'($urandom_range(0, 1));
      ex_memread = 1'($urandom_range(0, 1));
      mem_regwrite = 1'($urandom_range(0, 1));
      mem_memwrite = 1'($urandom_range(0, 1));
      wb_regwrite = 1'($urandom_range(0, 1));
      br_taken = ($urandom_range(0, 3) == 0);
      dmem_busy = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The module SHALL have parameter REG_W, default 4: register-number width.
REQ-002 The module SHALL have parameter NSRC, default 2: source operands per instruction.
REQ-003 The module SHALL have parameter LU_CYC, default 1: load-use bubbles, legal range 1..15.
REQ-004 The module SHALL have parameter FLUSH_CYC, default 1: squash cycles after a taken branch, legal range 1..15.
REQ-005 The module SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-006 The design SHALL use one clock; reset is synchronous and active-high, with ports as follows.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 id_src  in  NSRC*REG_W  IF/ID sources; slot i is [i*REG_W +: REG_W].
REQ-010 ex_src  in  NSRC*REG_W  ID/EX sources.
REQ-011 ex_dst, ex_regwrite, ex_memread  in  REG_W,1,1  ID/EX destination and controls.
REQ-012 mem_dst, mem_regwrite, mem_memwrite  in  REG_W,1,1  EX/MEM destination and controls.
REQ-013 mem_st_src  in  REG_W  EX/MEM store-data source register.
REQ-014 wb_dst, wb_regwrite  in  REG_W,1  MEM/WB destination and control.
REQ-015 br_taken  in  1  branch resolved taken in ID.
REQ-016 dmem_busy  in  1  data memory not ready.
REQ-017 fwd_sel  out  NSRC*2  per-slot ALU operand select.
REQ-018 mem_mem_fw  out  1  store-data forward from MEM/WB.
REQ-019 hold  out  4  bit0 PC+IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB.
REQ-020 no_op  out  4  bubble insert, same bit mapping as hold.
REQ-021 stall_cnt  out  CNT_W  cycles with any hold bit set.
REQ-022 state  out  2  FSM state: RUN=0, LU=1, FLUSH=2, MEMW=3.

Function
REQ-023 fwd_sel[2i+:2] SHALL be combinational: 01 if mem_regwrite and mem_dst!=0 and mem_dst==ex_src[i]; else 10 if wb_regwrite and wb_dst!=0 and wb_dst==ex_src[i]; else 00; the EX/MEM match wins.
REQ-024 mem_mem_fw SHALL equal mem_memwrite & wb_regwrite & (wb_dst!=0) & (wb_dst==mem_st_src).
REQ-025 A load-use condition SHALL be defined as ex_memread & (ex_dst!=0) & (any slot i with id_src[i]==ex_dst).
REQ-026 In RUN, events SHALL be prioritised dmem_busy > load-use > br_taken; lower-priority events in the same cycle are ignored.
REQ-027 On dmem_busy in RUN: hold=0111, no_op=1000 in that cycle; next state MEMW; the return state is saved as RUN.
REQ-028 On load-use in RUN: hold=0001, no_op=0010 in that cycle. If LU_CYC>1, next state is LU with the counter set to LU_CYC-1; otherwise the FSM stays in RUN.
REQ-029 In LU: hold=0001, no_op=0010; the counter decrements; the FSM returns to RUN when the counter reaches 0 (LU_CYC total bubbles).
REQ-030 On br_taken in RUN: no_op=0001, hold=0000. If FLUSH_CYC>1, next state is FLUSH with the counter set to FLUSH_CYC-1.
REQ-031 In FLUSH: no_op=0001; the counter decrements; the FSM returns to RUN at 0; br_taken is ignored.
REQ-032 dmem_busy in LU or FLUSH SHALL force MEMW next; the counter freezes and the current state is saved as the return state.
REQ-033 In MEMW: hold=0111, no_op=1000 while dmem_busy=1. On the first cycle with dmem_busy=0, outputs follow the return state's rules and the FSM returns there with the counter resumed.
REQ-034 In all other cases hold=0000 and no_op=0000.
REQ-035 stall_cnt SHALL increment by 1 on each clock edge where hold!=0 and saturate at 2^CNT_W-1.

Reset
REQ-036 With rst=1 at a clock edge: state=RUN, counter=0, return state=RUN, stall_cnt=0.
REQ-037 While rst=1: hold=0000 and no_op=0000 regardless of inputs; fwd_sel and mem_mem_fw stay combinational.
REQ-038 Reset asserted mid-LU, mid-FLUSH or mid-MEMW SHALL abort the operation with no residual stall.

Verification
REQ-039 Forward priority: ex_src slot0=3, mem_dst=3, wb_dst=3, both regwrite=1 -> fwd_sel[1:0]=01; then mem_dst=0 -> 10.
REQ-040 Load-use with LU_CYC=2: ex_memread=1, ex_dst=5, id_src slot1=5 -> hold=0001, no_op=0010 for exactly 2 cycles, state RUN->LU->RUN, stall_cnt=2.
REQ-041 Flush with FLUSH_CYC=3: br_taken pulse in RUN -> no_op=0001 for 3 cycles, hold=0 throughout.
REQ-042 Nested stall: dmem_busy=1 for 4 cycles starting in LU cycle 1 of 2 -> MEMW with hold=0111 for 4 cycles, then 1 remaining LU bubble.
REQ-043 Priority: load-use and br_taken together in RUN -> only the load-use bubble is inserted; dmem_busy added in the same cycle -> MEMW.
REQ-044 Saturation: CNT_W=3 with 10 stall cycles -> stall_cnt=7; rst mid-MEMW -> next cycle state=0, hold=0, stall_cnt=0.
